// File: rtl/sram_like_resp.sv
// ============================================================================
//  Module      : sram_like_resp
//  Description : SRAM-like slave with fixed-latency, in-order responses and
//                a bounded number of outstanding requests.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int         c_ptr_w    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [2:0] c_lat_init = 3'(LATENCY - 1);
    localparam logic [2:0] c_max_out  = 3'(MAX_OUT);

    logic [31:0]        mem_q [2**ADDR_W];

    logic [MAX_OUT-1:0] vld_q, vld_d;
    logic               is_rd_q [MAX_OUT];
    logic               is_rd_d [MAX_OUT];
    logic [31:0]        data_q  [MAX_OUT];
    logic [31:0]        data_d  [MAX_OUT];
    logic [2:0]         cnt_q   [MAX_OUT];
    logic [2:0]         cnt_d   [MAX_OUT];
    logic [c_ptr_w-1:0] head_q, head_d, tail_q, tail_d;
    logic [2:0]         count_q, count_d;
    logic               data_ok_q, data_ok_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [ADDR_W-1:0]  idx;
    logic [3:0]         be;
    logic               misaligned;
    logic               accept;
    logic               we;
    logic               retire;
    logic [31:0]        rd_word;
    logic [31:0]        wr_word;
    logic               unused_addr;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idx         = addr[ADDR_W+1:2];
    assign unused_addr = ^addr[31:ADDR_W+2];
    assign addr_ok     = rst | (count_q < c_max_out);
    assign accept      = req & addr_ok & ~rst;
    assign misaligned  = ((size == 2'd1) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));
    assign we          = accept & wr & ~misaligned;
    assign rd_word     = mem_q[idx];
    assign data_ok     = data_ok_q & ~rst;
    assign rdata       = rst ? 32'h0 : rdata_q;

    always_comb begin
        be = 4'b1111;
        case (size)
            2'd0:    be = 4'b0001 << addr[1:0];
            2'd1:    be = 4'b0011 << addr[1:0];
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                wr_word[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // Memory is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wr_word;
        end
    end

    always_comb begin
        vld_d     = vld_q;
        head_d    = head_q;
        tail_d    = tail_q;
        data_ok_d = 1'b0;
        rdata_d   = 32'h0;
        for (int i = 0; i < MAX_OUT; i++) begin
            is_rd_d[i] = is_rd_q[i];
            data_d[i]  = data_q[i];
            cnt_d[i]   = (vld_q[i] && (cnt_q[i] != 3'd0)) ? cnt_q[i] - 3'd1 : cnt_q[i];
        end

        // Fixed latency plus in-order push means only the head can expire.
        retire = vld_q[head_q] && (cnt_q[head_q] == 3'd0);
        if (retire) begin
            data_ok_d      = 1'b1;
            rdata_d        = is_rd_q[head_q] ? data_q[head_q] : 32'h0;
            vld_d[head_q]  = 1'b0;
            head_d         = ptr_inc(head_q);
        end

        if (accept) begin
            vld_d[tail_q]   = 1'b1;
            is_rd_d[tail_q] = ~wr;
            data_d[tail_q]  = wr ? 32'h0 : rd_word;
            cnt_d[tail_q]   = c_lat_init;
            tail_d          = ptr_inc(tail_q);
        end

        count_d = count_q + {2'b00, accept} - {2'b00, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 3'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            vld_q     <= vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUT; i++) begin
            is_rd_q[i] <= is_rd_d[i];
            data_q[i]  <= data_d[i];
            cnt_q[i]   <= cnt_d[i];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_like_resp.sv
// ============================================================================
//  Module      : tb_sram_like_resp
//  Description : Directed self-checking bench for sram_like_resp (defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_like_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int n_pass  = 0;
    int n_total = 0;

    sram_like_resp #(
        .ADDR_W  (10),
        .LATENCY (2),
        .MAX_OUT (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    // One isolated request; response must appear exactly 2 edges after accept.
    task automatic single(input string tag, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp);
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
        chk({tag, "_aok"}, {31'b0, addr_ok}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        chk({tag, "_dok_t0"}, {31'b0, data_ok}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_dok_t1"}, {31'b0, data_ok}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_dok_t2"}, {31'b0, data_ok}, 32'd1);
        chk({tag, "_rdata"},  rdata, exp);
        @(posedge clk); #1;
        chk({tag, "_dok_t3"}, {31'b0, data_ok}, 32'd0);
        chk({tag, "_rdata_idle"}, rdata, 32'h0);
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
        req = r; wr = w; size = 2'd2; addr = a; wdata = wd;
    endtask

    task automatic look(input string tag, input logic aok, input logic dok, input logic [31:0] rd);
        chk({tag, "_aok"},   {31'b0, addr_ok}, {31'b0, aok});
        chk({tag, "_dok"},   {31'b0, data_ok}, {31'b0, dok});
        chk({tag, "_rdata"}, rdata, rd);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        look("rst_hold", 1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        look("rst_done", 1'b1, 1'b0, 32'h0);

        // Word write/read, byte and halfword lanes, misaligned and wrap cases
        single("wr_word",  1'b1, 2'd2, 32'h10,   32'hDEADBEEF, 32'h0);
        single("rd_word",  1'b0, 2'd2, 32'h10,   32'h0,        32'hDEADBEEF);
        single("wr_w20",   1'b1, 2'd2, 32'h20,   32'h11223344, 32'h0);
        single("wr_byte",  1'b1, 2'd0, 32'h22,   32'h00AA0000, 32'h0);
        single("rd_byte",  1'b0, 2'd2, 32'h20,   32'h0,        32'h11AA3344);
        single("wr_w24",   1'b1, 2'd2, 32'h24,   32'h01020304, 32'h0);
        single("wr_half",  1'b1, 2'd1, 32'h26,   32'hBEEF0000, 32'h0);
        single("wr_hmis",  1'b1, 2'd1, 32'h25,   32'h00FFFF00, 32'h0);
        single("rd_half",  1'b0, 2'd2, 32'h24,   32'h0,        32'hBEEF0304);
        single("wr_w30",   1'b1, 2'd2, 32'h30,   32'h0,        32'h0);
        single("wr_mis",   1'b1, 2'd3, 32'h31,   32'h55555555, 32'h0);
        single("rd_mis",   1'b0, 2'd2, 32'h30,   32'h0,        32'h0);
        single("wr_wrap",  1'b1, 2'd2, 32'h1004, 32'hCAFE0001, 32'h0);
        single("rd_wrap",  1'b0, 2'd2, 32'h4,    32'h0,        32'hCAFE0001);

        // Write immediately followed by a read of the same word
        @(negedge clk); drive(1'b1, 1'b1, 32'h40, 32'h12345678);
        @(negedge clk); drive(1'b1, 1'b0, 32'h40, 32'h0);
        chk("raw_aok1", {31'b0, addr_ok}, 32'd1);
        @(negedge clk); req = 1'b0;
        look("raw_n2", 1'b0, 1'b0, 32'h0);
        @(negedge clk); look("raw_n3", 1'b1, 1'b1, 32'h0);
        @(negedge clk); look("raw_n4", 1'b1, 1'b1, 32'h12345678);
        @(negedge clk); look("raw_n5", 1'b1, 1'b0, 32'h0);

        // Read snapshot must not see a write accepted after it
        @(negedge clk); drive(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk); drive(1'b1, 1'b1, 32'h40, 32'h99999999);
        @(negedge clk); req = 1'b0;
        @(negedge clk); look("snap_rd", 1'b1, 1'b1, 32'h12345678);
        @(negedge clk); look("snap_wr", 1'b1, 1'b1, 32'h0);
        @(negedge clk); look("snap_end", 1'b1, 1'b0, 32'h0);

        // Back-pressure: four reads with req held high
        @(negedge clk); drive(1'b1, 1'b0, 32'h10, 32'h0);
        chk("bp_n0_aok", {31'b0, addr_ok}, 32'd1);
        @(negedge clk); look("bp_n1", 1'b1, 1'b0, 32'h0); addr = 32'h20;
        @(negedge clk); look("bp_n2", 1'b0, 1'b0, 32'h0); addr = 32'h04;
        @(negedge clk); look("bp_n3", 1'b1, 1'b1, 32'hDEADBEEF);
        @(negedge clk); look("bp_n4", 1'b1, 1'b1, 32'h11AA3344); addr = 32'h40;
        @(negedge clk); look("bp_n5", 1'b0, 1'b0, 32'h0); req = 1'b0;
        @(negedge clk); look("bp_n6", 1'b1, 1'b1, 32'hCAFE0001);
        @(negedge clk); look("bp_n7", 1'b1, 1'b1, 32'h99999999);
        @(negedge clk); look("bp_n8", 1'b1, 1'b0, 32'h0);

        // Reset one edge after a read is accepted
        @(negedge clk); drive(1'b1, 1'b0, 32'h10, 32'h0);
        chk("mrst_aok", {31'b0, addr_ok}, 32'd1);
        @(negedge clk); req = 1'b0; rst = 1'b1;
        #1 look("mrst_during", 1'b1, 1'b0, 32'h0);
        @(negedge clk); rst = 1'b0;
        look("mrst_after", 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            look($sformatf("mrst_quiet%0d", i), 1'b1, 1'b0, 32'h0);
        end

        // Queue must be empty after reset: two accepts, then back-pressure
        @(negedge clk); drive(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk); look("post_n1", 1'b1, 1'b0, 32'h0); addr = 32'h20;
        @(negedge clk); look("post_n2", 1'b0, 1'b0, 32'h0); req = 1'b0;
        @(negedge clk); look("post_n3", 1'b1, 1'b1, 32'hDEADBEEF);
        @(negedge clk); look("post_n4", 1'b1, 1'b1, 32'h11AA3344);
        @(negedge clk); look("post_n5", 1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_like_resp.md
SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, number of word-index bits (memory of 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, legal 1..7, cycles from request acceptance to data_ok.
REQ-003 SHALL have parameter MAX_OUT, default 2, legal 1..4, maximum outstanding accepted-but-unanswered requests.
REQ-004 SHALL have one clock and a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  1  initiator request valid.
REQ-008 wr  input  1  1 = write, 0 = read.
REQ-009 size  input  2  0 byte, 1 halfword, 2 word, 3 treated as word.
REQ-010 addr  input  32  byte address.
REQ-011 wdata  input  32  write data, byte lanes aligned to addr[1:0].
REQ-012 addr_ok  output  1  request accepted this cycle when req is also high.
REQ-013 data_ok  output  1  one-cycle response strobe.
REQ-014 rdata  output  32  read word, valid while data_ok is high.

Function
REQ-015 SHALL drive addr_ok combinationally as (outstanding count < MAX_OUT), independent of req.
REQ-016 SHALL accept a request in exactly the cycles where req && addr_ok, with at most one acceptance per cycle.
REQ-017 SHALL index memory with addr[ADDR_W+1:2] and ignore the upper address bits, so addresses wrap modulo 2^(ADDR_W+2).
REQ-018 SHALL perform an accepted write on the acceptance edge, using byte enables of 0001<<addr[1:0] for size 0, 0011<<addr[1:0] for size 1, and 1111 for size 2/3.
REQ-019 SHALL suppress the write, but still respond, when the write is misaligned: size 1 with addr[0]=1, or size 2/3 with addr[1:0]!=0.
REQ-020 SHALL snapshot the full aligned word on the acceptance edge of a read, which fixes the result against any later write.
REQ-021 SHALL push each accepted request into an in-order queue of depth MAX_OUT holding {is_read, data, countdown = LATENCY-1}.
REQ-022 SHALL decrement the countdown of every queued entry each cycle.
REQ-023 SHALL register data_ok high for exactly the one cycle at T+LATENCY for a request accepted at edge T, then pop that entry on the same edge.
REQ-024 SHALL output the snapshot on rdata when data_ok is high for a read, and 0 when data_ok is high for a write.
REQ-025 SHALL hold rdata at 0 whenever data_ok is low.
REQ-026 SHALL return responses strictly in acceptance order, at most one per cycle.
REQ-027 SHALL update the outstanding count as +1 on accept, -1 on retire, and unchanged when both happen in the same cycle.
REQ-028 SHALL reach addr_ok high again no earlier than the cycle after the retire edge once the queue is full.
REQ-029 SHALL give a same-cycle read and an earlier write to the same word, accepted on consecutive edges, the already-written data.

Reset
REQ-030 SHALL, while rst is high, clear the outstanding count to 0 and the queue valid bits, drive data_ok=0, rdata=0, and addr_ok=1, and block any write to memory.
REQ-031 SHALL discard requests outstanding at the time of a mid-operation reset, and never issue a data_ok for them.
REQ-032 SHALL leave memory contents unchanged through reset, with no clearing.

Verification
REQ-033 Write word: addr=0x10, wdata=0xDEADBEEF, size=2, then read 0x10 with LATENCY=2 -> read data_ok exactly 2 cycles after its accept, rdata=0xDEADBEEF.
REQ-034 Byte lanes: word 0x11223344 at 0x20, then write byte 0xAA at 0x22 (size 0), then read 0x20 -> rdata=0x11AA3344.
REQ-035 Back-pressure: req held high for 4 back-to-back reads with MAX_OUT=2 and LATENCY=2 -> addr_ok low on the 3rd cycle, responses in order, never two outstanding beyond 2, no data_ok gaps violating T+LATENCY.
REQ-036 Misaligned: word write 0x55555555 at 0x31 after 0x0 in that word -> data_ok asserted, subsequent read of 0x30 returns 0x00000000.
REQ-037 Wrap: ADDR_W=10, write 0xCAFE0001 at 0x00001004 -> read of 0x00000004 returns 0xCAFE0001.
REQ-038 Reset mid-flight: accept read, assert rst on the next edge for 1 cycle -> no data_ok ever for that read, addr_ok=1, count=0 after reset.
